multiplier_bank: RTL and testbench

MULTIPLIER_BANK -- requirements
Module: multiplier_bank

---
 rtl/multiplier_bank.sv | 166 ++++++++++++++++
 tb/tb_multiplier_bank.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/multiplier_bank.sv
// Bank of CHANNELS signed Q1.(BITSIZE-1) multipliers (ring or AM), one serial shift-add unit shared across channels.
// Latency: done pulses CHANNELS*(BITSIZE+2)+1 cycles after the synchronised lrclk rising edge.
// No backpressure: frame starts arriving while busy are dropped and flagged on sticky overrun; MULTIPLIER_BANK_SATURATE_EN clamps the one overflow case.
module multiplier_bank #(
  parameter int BITSIZE  = 16,
  parameter int CHANNELS = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         lrclk,
  input  logic [CHANNELS-1:0]          mode,
  input  logic [CHANNELS*BITSIZE-1:0]  in1,
  input  logic [CHANNELS*BITSIZE-1:0]  in2,
  output logic [CHANNELS*BITSIZE-1:0]  out,
  output logic                         busy,
  output logic                         done,
  output logic                         overrun
);

  localparam int PW = 2 * BITSIZE;
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int NW = $clog2(BITSIZE + 1);
  localparam logic [BITSIZE-1:0] HALF = BITSIZE'(1) << (BITSIZE - 2);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MUL, S_STORE, S_FIN} state_t;

  // lrclk synchroniser and edge detector
  logic       sync1_q, sync2_q, prev_q;
  logic [1:0] vld_q;
  logic       rise_w;

  // Datapath / FSM state
  state_t                        state_q;
  logic [CW-1:0]                 ch_q;
  logic [NW-1:0]                 cnt_q;
  logic [PW-1:0]                 acc_q, mcand_q;
  logic [BITSIZE-1:0]            mplier_q;
  logic [CHANNELS*BITSIZE-1:0]   in1_q, in2_q, out_q;
  logic [CHANNELS-1:0]           mode_q;
  logic                          busy_q, done_q, overrun_q;

  // Next-value helpers
  logic [BITSIZE-1:0]            a_sel, b_sel, b_am, mplier_d, res_d;
  logic                          m_sel;
  logic [PW-1:0]                 mcand_d;
  logic                          unused_acc_bits;

  // Two-flop synchroniser; prev is held high until sync2 carries real samples,
  // so lrclk already high when reset releases does not look like a rising edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      vld_q   <= 2'b00;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= lrclk;
      sync2_q <= sync1_q;
      vld_q   <= {vld_q[0], 1'b1};
      prev_q  <= vld_q[1] ? sync2_q : 1'b1;
    end
  end

  assign rise_w = vld_q[1] & sync2_q & ~prev_q;

  // Select the current channel's latched operands; AM maps in2 to a non-negative gain
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    m_sel = 1'b0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (ch_q == CW'(c)) begin
        a_sel = in1_q[c*BITSIZE +: BITSIZE];
        b_sel = in2_q[c*BITSIZE +: BITSIZE];
        m_sel = mode_q[c];
      end
    end
    b_am     = $unsigned($signed(b_sel) >>> 1) + HALF;
    mplier_d = m_sel ? b_am : b_sel;
    mcand_d  = {{BITSIZE{a_sel[BITSIZE-1]}}, a_sel};
  end

  // Rescale the full product back to Q1.(BITSIZE-1); only (-1)*(-1) can overflow
  always_comb begin
    res_d = acc_q[PW-2:BITSIZE-1];
`ifdef MULTIPLIER_BANK_SATURATE_EN
    if (!acc_q[PW-1] && acc_q[PW-2]) res_d = {1'b0, {(BITSIZE-1){1'b1}}};
`endif
  end

  assign unused_acc_bits = ^{acc_q[PW-1], acc_q[BITSIZE-2:0]};

  // Frame sequencer: per channel LOAD, BITSIZE shift-add steps, STORE; then FIN
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      ch_q      <= '0;
      cnt_q     <= '0;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      in1_q     <= '0;
      in2_q     <= '0;
      mode_q    <= '0;
      out_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      if (rise_w && state_q != S_IDLE) overrun_q <= 1'b1;
      case (state_q)
        S_IDLE: begin
          if (rise_w) begin
            in1_q   <= in1;
            in2_q   <= in2;
            mode_q  <= mode;
            ch_q    <= '0;
            busy_q  <= 1'b1;
            state_q <= S_LOAD;
          end
        end
        S_LOAD: begin
          acc_q    <= '0;
          mcand_q  <= mcand_d;
          mplier_q <= mplier_d;
          cnt_q    <= '0;
          state_q  <= S_MUL;
        end
        S_MUL: begin
          // The multiplier MSB carries negative weight, so its partial product is subtracted
          if (mplier_q[0]) begin
            acc_q <= (cnt_q == NW'(BITSIZE-1)) ? acc_q - mcand_q : acc_q + mcand_q;
          end
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + NW'(1);
          if (cnt_q == NW'(BITSIZE-1)) state_q <= S_STORE;
        end
        S_STORE: begin
          for (int c = 0; c < CHANNELS; c++) begin
            if (ch_q == CW'(c)) out_q[c*BITSIZE +: BITSIZE] <= res_d;
          end
          if (ch_q == CW'(CHANNELS-1)) begin
            done_q  <= 1'b1;
            state_q <= S_FIN;
          end else begin
            ch_q    <= ch_q + CW'(1);
            state_q <= S_LOAD;
          end
        end
        S_FIN: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign out     = out_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_multiplier_bank.sv
// Self-checking bench for multiplier_bank (BITSIZE=16, CHANNELS=2).
// Cycle k counts rising clk edges after lrclk is driven high; the edge cycle T begins after edge 2.
// Products are predicted with plain integer arithmetic from the fixed-point definitions.
module tb_multiplier_bank;
  localparam int B = 16;
  localparam int C = 2;

  logic           clk = 1'b0;
  logic           reset;
  logic           lrclk;
  logic [C-1:0]   mode;
  logic [C*B-1:0] in1, in2, out;
  logic           busy, done, overrun;

  int errors = 0;
  int checks = 0;
  int bk, dk, dc, bc, c0k, c1k;

  always #5 clk = ~clk;

  multiplier_bank #(.BITSIZE(B), .CHANNELS(C)) dut (
    .clk(clk), .reset(reset), .lrclk(lrclk), .mode(mode),
    .in1(in1), .in2(in2), .out(out),
    .busy(busy), .done(done), .overrun(overrun)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Fixed-point reference: a*b (or a*m for AM) rescaled by 2^-(B-1)
  function automatic logic [B-1:0] ref_mul(input logic [B-1:0] x, input logic [B-1:0] y, input logic am);
    int a, b, p, q;
    logic [B-1:0] r;
    a = int'($signed(x));
    b = int'($signed(y));
    if (am) b = (b >>> 1) + (1 << (B-2));
    p = a * b;
    q = p >>> (B-1);
    r = q[B-1:0];
`ifdef MULTIPLIER_BANK_SATURATE_EN
    if (p == (1 << (2*B-2))) r = {1'b0, {(B-1){1'b1}}};
`endif
    return r;
  endfunction

  function automatic logic [C*B-1:0] ref_frame(input logic [C*B-1:0] x, input logic [C*B-1:0] y, input logic [C-1:0] m);
    logic [C*B-1:0] r;
    r = '0;
    for (int c = 0; c < C; c++) r[c*B +: B] = ref_mul(x[c*B +: B], y[c*B +: B], m[c]);
    return r;
  endfunction

  // Drives one lrclk rise and observes nticks cycles; optional disturbances at given cycles
  task automatic run_frame(input int scramble_at, input int second_at, input int reset_at, input int nticks);
    logic [C*B-1:0] prev_out;
    bk = -1; dk = -1; dc = 0; bc = 0; c0k = -1; c1k = -1;
    prev_out = out;
    lrclk = 1'b1;
    for (int k = 1; k <= nticks; k++) begin
      tick;
      if (busy) begin bc++; if (bk < 0) bk = k; end
      if (done) begin dc++; if (dk < 0) dk = k; end
      if (out[B-1:0] !== prev_out[B-1:0]) c0k = k;
      if (out[2*B-1:B] !== prev_out[2*B-1:B]) c1k = k;
      prev_out = out;
      if (k == 4) lrclk = 1'b0;
      if (k == scramble_at) begin in1 = (C*B)'($urandom); in2 = (C*B)'($urandom); mode = C'($urandom); end
      if (k == second_at) lrclk = 1'b1;
      if (second_at > 0 && k == second_at + 3) lrclk = 1'b0;
      if (k == reset_at) reset = 1'b0;
      if (reset_at > 0 && k == reset_at + 2) reset = 1'b1;
    end
  endtask

  task automatic do_reset;
    reset = 1'b0;
    tick; tick;
    reset = 1'b1;
    tick; tick; tick;
  endtask

  task automatic test_reset;
    int hb;
    reset = 1'b0; lrclk = 1'b0; mode = '0; in1 = '0; in2 = '0;
    tick; tick; tick;
    checks++; if (out !== '0) begin errors++; $display("FAIL reset_out: got %h want 0", out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    // lrclk already high when reset releases must not start a frame
    lrclk = 1'b1;
    tick;
    reset = 1'b1;
    hb = 0;
    for (int k = 0; k < 50; k++) begin tick; if (busy || done) hb++; end
    checks++; if (hb != 0) begin errors++; $display("FAIL held_high_start: got %0d busy cycles want 0", hb); end
    lrclk = 1'b0;
    tick; tick; tick;
  endtask

  task automatic test_ring;
    logic [C*B-1:0] exp;
    in1 = {16'hC000, 16'h4000}; in2 = {16'h4000, 16'h4000}; mode = 2'b00;
    exp = ref_frame(in1, in2, mode);
    run_frame(-1, -1, -1, 60);
    checks++; if (out !== exp) begin errors++; $display("FAIL ring_out: got %h want %h", out, exp); end
    checks++; if (bk != 3) begin errors++; $display("FAIL ring_busy_start: got %0d want 3", bk); end
    checks++; if (dk != 39) begin errors++; $display("FAIL ring_done_cycle: got %0d want 39", dk); end
    checks++; if (dc != 1) begin errors++; $display("FAIL ring_done_pulses: got %0d want 1", dc); end
    checks++; if (bc != 37) begin errors++; $display("FAIL ring_busy_len: got %0d want 37", bc); end
    checks++; if (c0k != 21) begin errors++; $display("FAIL ring_ch0_update: got %0d want 21", c0k); end
    checks++; if (c1k != 39) begin errors++; $display("FAIL ring_ch1_update: got %0d want 39", c1k); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ring_overrun: got %b want 0", overrun); end
  endtask

  task automatic test_corner;
    logic [B-1:0] e0;
`ifdef MULTIPLIER_BANK_SATURATE_EN
    e0 = 16'h7FFF;
`else
    e0 = 16'h8000;
`endif
    in1 = {16'h4000, 16'h8000}; in2 = {16'h8000, 16'h8000}; mode = 2'b10;
    run_frame(-1, -1, -1, 45);
    checks++; if (out[B-1:0] !== e0) begin errors++; $display("FAIL corner_min_sq: got %h want %h", out[B-1:0], e0); end
    checks++; if (out[2*B-1:B] !== 16'h0000) begin errors++; $display("FAIL corner_am_min: got %h want 0000", out[2*B-1:B]); end
  endtask

  task automatic test_am;
    logic [C*B-1:0] exp;
    in1 = {16'h4000, 16'h4000}; in2 = {16'h7FFF, 16'h0000}; mode = 2'b11;
    exp = ref_frame(in1, in2, mode);
    run_frame(-1, -1, -1, 45);
    checks++; if (out !== exp) begin errors++; $display("FAIL am_out: got %h want %h", out, exp); end
    checks++; if (out[2*B-1:B] !== 16'h3FFF) begin errors++; $display("FAIL am_full_scale: got %h want 3fff", out[2*B-1:B]); end
  endtask

  task automatic test_input_hold;
    logic [C*B-1:0] exp;
    in1 = (C*B)'($urandom); in2 = (C*B)'($urandom); mode = C'($urandom);
    exp = ref_frame(in1, in2, mode);
    run_frame(3, -1, -1, 45);
    checks++; if (out !== exp) begin errors++; $display("FAIL input_hold: got %h want %h", out, exp); end
  endtask

  task automatic test_overrun;
    logic [C*B-1:0] exp;
    in1 = (C*B)'($urandom); in2 = (C*B)'($urandom); mode = C'($urandom);
    exp = ref_frame(in1, in2, mode);
    run_frame(-1, 10, -1, 60);
    checks++; if (out !== exp) begin errors++; $display("FAIL overrun_out: got %h want %h", out, exp); end
    checks++; if (dk != 39) begin errors++; $display("FAIL overrun_done_cycle: got %0d want 39", dk); end
    checks++; if (bc != 37 || dc != 1) begin errors++; $display("FAIL overrun_restart: got busy=%0d done=%0d want 37/1", bc, dc); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_flag: got %b want 1", overrun); end
    run_frame(-1, -1, -1, 45);
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_sticky: got %b want 1", overrun); end
  endtask

  task automatic test_fin_edge;
    logic [C*B-1:0] exp;
    do_reset;
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_clear: got %b want 0", overrun); end
    in1 = (C*B)'($urandom); in2 = (C*B)'($urandom); mode = C'($urandom);
    exp = ref_frame(in1, in2, mode);
    // edge lands in the FIN cycle: ignored
    run_frame(-1, 37, -1, 80);
    checks++; if (dc != 1 || bc != 37) begin errors++; $display("FAIL fin_edge_ignored: got done=%0d busy=%0d want 1/37", dc, bc); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL fin_edge_overrun: got %b want 1", overrun); end
    // edge one cycle after FIN: a second full frame
    run_frame(-1, 38, -1, 90);
    checks++; if (dc != 2 || bc != 74) begin errors++; $display("FAIL post_fin_start: got done=%0d busy=%0d want 2/74", dc, bc); end
    checks++; if (out !== exp) begin errors++; $display("FAIL post_fin_out: got %h want %h", out, exp); end
  endtask

  task automatic test_reset_midframe;
    logic [C*B-1:0] exp;
    in1 = (C*B)'($urandom) | 32'h0100_0100; in2 = 32'h4000_4000; mode = 2'b00;
    run_frame(-1, -1, 22, 60);
    checks++; if (dc != 0) begin errors++; $display("FAIL midreset_done: got %0d pulses want 0", dc); end
    checks++; if (bc != 20) begin errors++; $display("FAIL midreset_busy: got %0d cycles want 20", bc); end
    checks++; if (out !== '0) begin errors++; $display("FAIL midreset_out: got %h want 0", out); end
    checks++; if (busy !== 1'b0 || overrun !== 1'b0) begin errors++; $display("FAIL midreset_flags: got busy=%b overrun=%b want 0/0", busy, overrun); end
    in1 = (C*B)'($urandom); in2 = (C*B)'($urandom); mode = C'($urandom);
    exp = ref_frame(in1, in2, mode);
    run_frame(-1, -1, -1, 45);
    checks++; if (out !== exp || dk != 39) begin errors++; $display("FAIL midreset_next: got %h at %0d want %h at 39", out, dk, exp); end
  endtask

  task automatic test_random;
    logic [C*B-1:0] exp;
    for (int n = 0; n < 15; n++) begin
      in1 = (C*B)'($urandom); in2 = (C*B)'($urandom); mode = C'($urandom);
      exp = ref_frame(in1, in2, mode);
      run_frame(-1, -1, -1, 45);
      for (int c = 0; c < C; c++) begin
        checks++;
        if (out[c*B +: B] !== exp[c*B +: B]) begin
          errors++;
          $display("FAIL random_f%0d_ch%0d: got %h want %h (in1=%h in2=%h mode=%b)", n, c, out[c*B +: B], exp[c*B +: B], in1, in2, mode);
        end
      end
      checks++; if (dk != 39) begin errors++; $display("FAIL random_f%0d_done: got %0d want 39", n, dk); end
    end
  endtask

  initial begin
    test_reset;
    test_ring;
    test_corner;
    test_am;
    test_input_hold;
    test_overrun;
    test_fin_edge;
    test_reset_midframe;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
